servant_uart_rx: RTL and testbench



---
 rtl/servant_uart_rx.sv | 245 ++++++++++++++++++++++++
 tb/tb_servant_uart_rx.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/servant_uart_rx.sv
// Wishbone-responder UART receiver: oversampled 8N1 framing, small receive FIFO, status and interrupt.
// Optional even-parity (8E1) framing is enabled by defining SERVANT_UART_RX_PARITY_EN.
module servant_uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_wb_adr,
    input  logic        i_wb_cyc,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_dat,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    input  logic        i_rx,
    output logic        o_irq
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT/2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
`ifdef SERVANT_UART_RX_PARITY_EN
        ST_PAR   = 3'd3,
`endif
        ST_STOP  = 3'd4
    } state_t;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

    logic          rx_meta_r, rxs_r, rxs_prev_r;
    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic [2:0]    bit_idx_r;
    logic [7:0]    shift_r;
    logic          par_bad_s;
    logic          tick_s, push_s, ferr_set_s, perr_set_s;

    logic [7:0]    mem_r [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_r, rd_ptr_r;
    logic          empty_s, full_s, pop_s, ovr_set_s, do_push_s;
    logic [7:0]    head_s;

    logic          ack_r, pop_pend_r, ovr_r, ferr_r, irq_en_r, perr_flag_s;
    logic [31:0]   rdt_r, status_s, rd_word_s;
    logic          req_s, rd_s, wr_status_s;
    logic          unused_wdat_s;

    assign unused_wdat_s = ^i_wb_dat;

    // Two-flop synchronizer plus one more stage for falling-edge detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta_r  <= 1'b1;
            rxs_r      <= 1'b1;
            rxs_prev_r <= 1'b1;
        end else begin
            rx_meta_r  <= i_rx;
            rxs_r      <= rx_meta_r;
            rxs_prev_r <= rxs_r;
        end
    end

    assign tick_s = (cnt_r == {CW{1'b0}});

`ifdef SERVANT_UART_RX_PARITY_EN
    logic par_bad_r;
    logic perr_r;
    assign par_bad_s   = par_bad_r;
    assign perr_flag_s = perr_r;
`else
    assign par_bad_s   = 1'b0;
    assign perr_flag_s = 1'b0;
`endif

    // Receiver FSM: the counter runs down in every state and each zero is one sample point.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CW{1'b0}};
            bit_idx_r <= 3'd0;
            shift_r   <= 8'd0;
`ifdef SERVANT_UART_RX_PARITY_EN
            par_bad_r <= 1'b0;
`endif
        end else begin
            cnt_r <= cnt_r - CNT_ONE;
            case (state_r)
                ST_IDLE: begin
                    if (rxs_prev_r && !rxs_r) begin
                        cnt_r   <= CNT_HALF;
                        state_r <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick_s) begin
                        cnt_r     <= CNT_FULL;
                        bit_idx_r <= 3'd0;
                        state_r   <= rxs_r ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick_s) begin
                        cnt_r     <= CNT_FULL;
                        shift_r   <= {rxs_r, shift_r[7:1]};
                        bit_idx_r <= bit_idx_r + 3'd1;
                        if (bit_idx_r == 3'd7) begin
`ifdef SERVANT_UART_RX_PARITY_EN
                            state_r <= ST_PAR;
`else
                            state_r <= ST_STOP;
`endif
                        end
                    end
                end
`ifdef SERVANT_UART_RX_PARITY_EN
                ST_PAR: begin
                    if (tick_s) begin
                        cnt_r     <= CNT_FULL;
                        par_bad_r <= (rxs_r != even_parity(shift_r));
                        state_r   <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (tick_s) begin
                        cnt_r   <= CNT_FULL;
                        state_r <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Frame outcome is decided combinationally at the stop sample so it lands one cycle later.
    always_comb begin
        push_s     = 1'b0;
        ferr_set_s = 1'b0;
        perr_set_s = 1'b0;
        if ((state_r == ST_STOP) && tick_s) begin
            ferr_set_s = !rxs_r;
            perr_set_s = par_bad_s;
            push_s     = rxs_r && !par_bad_s;
        end else begin
            push_s     = 1'b0;
        end
    end

    assign empty_s   = (wr_ptr_r == rd_ptr_r);
    assign full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign head_s    = mem_r[rd_ptr_r[AW-1:0]];
    assign pop_s     = pop_pend_r;
    assign do_push_s = push_s && (!full_s || pop_s);
    assign ovr_set_s = push_s && full_s && !pop_s;

    // FIFO storage; contents are don't-care once the pointers are reset.
    always_ff @(posedge i_clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= shift_r;
        end
    end

    // FIFO pointers with an extra wrap bit to tell full from empty.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    assign req_s       = i_wb_cyc && !ack_r;
    assign rd_s        = req_s && !i_wb_we;
    assign wr_status_s = req_s && i_wb_we && i_wb_adr;
    assign status_s    = {23'd0, irq_en_r, 3'd0, perr_flag_s, ferr_r, ovr_r, full_s, !empty_s};

    // Read mux: an empty DATA read returns zero.
    always_comb begin
        rd_word_s = 32'd0;
        if (i_wb_adr) begin
            rd_word_s = status_s;
        end else if (!empty_s) begin
            rd_word_s = {24'd0, head_s};
        end else begin
            rd_word_s = 32'd0;
        end
    end

    // Bus responder: one-cycle ack, data only in the ack cycle, DATA pop at the end of the ack.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ack_r      <= 1'b0;
            rdt_r      <= 32'd0;
            pop_pend_r <= 1'b0;
        end else begin
            ack_r      <= req_s;
            rdt_r      <= rd_s ? rd_word_s : 32'd0;
            pop_pend_r <= rd_s && !i_wb_adr && !empty_s;
        end
    end

    // Sticky flags: a set in the same cycle as a write-one-to-clear wins.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ovr_r    <= 1'b0;
            ferr_r   <= 1'b0;
            irq_en_r <= 1'b0;
`ifdef SERVANT_UART_RX_PARITY_EN
            perr_r   <= 1'b0;
`endif
        end else begin
            ovr_r  <= ovr_set_s  || (ovr_r  && !(wr_status_s && i_wb_dat[2]));
            ferr_r <= ferr_set_s || (ferr_r && !(wr_status_s && i_wb_dat[3]));
`ifdef SERVANT_UART_RX_PARITY_EN
            perr_r <= perr_set_s || (perr_r && !(wr_status_s && i_wb_dat[4]));
`endif
            if (wr_status_s) begin
                irq_en_r <= i_wb_dat[8];
            end
        end
    end

    logic unused_perr_s;
    assign unused_perr_s = perr_set_s;

    assign o_wb_ack = ack_r;
    assign o_wb_rdt = rdt_r;
    assign o_irq    = irq_en_r && (!empty_s || ovr_r);

endmodule

// File: tb/tb_servant_uart_rx.sv
// Self-checking bench for servant_uart_rx: directed scenarios plus randomized frames and bus traffic,
// compared every cycle against a queue-based model of the receiver.
module tb_servant_uart_rx;
    localparam int CPB   = 16;
    localparam int DEPTH = 4;
`ifdef SERVANT_UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // Outcome edge after the start-bit edge: 2 sync flops, 1 edge detect, half a bit, stop index.
    localparam int FRAME_DUE = 3 + CPB/2 + (NBITS-1)*CPB;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_wb_adr = 1'b0;
    logic        i_wb_cyc = 1'b0;
    logic        i_wb_we = 1'b0;
    logic [31:0] i_wb_dat = 32'd0;
    logic [31:0] o_wb_rdt;
    logic        o_wb_ack;
    logic        i_rx = 1'b1;
    logic        o_irq;

    servant_uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wb_adr(i_wb_adr), .i_wb_cyc(i_wb_cyc),
        .i_wb_we(i_wb_we), .i_wb_dat(i_wb_dat), .o_wb_rdt(o_wb_rdt), .o_wb_ack(o_wb_ack),
        .i_rx(i_rx), .o_irq(o_irq)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int         due;
        logic [7:0] d;
        bit         stop_ok;
        bit         par_ok;
    } ev_t;

    ev_t         evq[$];
    logic [7:0]  q[$];
    int          cyc_cnt = 0;
    logic        m_ack = 1'b0, m_pop = 1'b0;
    logic [31:0] m_rdt = 32'd0;
    logic        m_ovr = 1'b0, m_ferr = 1'b0, m_perr = 1'b0, m_irq_en = 1'b0;

    function automatic logic [31:0] m_status();
        return {23'd0, m_irq_en, 3'd0, m_perr, m_ferr, m_ovr, (q.size() == DEPTH), (q.size() > 0)};
    endfunction

    // Reference model: what each clock edge must do to the receiver's visible state.
    always @(posedge i_clk) begin
        bit   req, do_pop, f_push, f_ovr, f_ferr, f_perr;
        ev_t  e;
        cyc_cnt++;
        if (!i_rst_n) begin
            q.delete(); evq.delete();
            m_ack = 1'b0; m_pop = 1'b0; m_rdt = 32'd0;
            m_ovr = 1'b0; m_ferr = 1'b0; m_perr = 1'b0; m_irq_en = 1'b0;
        end else begin
            req = i_wb_cyc && !m_ack;
            do_pop = m_pop;
            f_push = 1'b0; f_ovr = 1'b0; f_ferr = 1'b0; f_perr = 1'b0;
            if (evq.size() > 0 && evq[0].due == cyc_cnt) begin
                e = evq.pop_front();
                f_ferr = !e.stop_ok;
                f_perr = !e.par_ok;
                f_push = e.stop_ok && e.par_ok;
            end
            if (req && !i_wb_we) begin
                m_rdt = i_wb_adr ? m_status() : ((q.size() > 0) ? {24'd0, q[0]} : 32'd0);
                m_pop = !i_wb_adr && (q.size() > 0);
            end else begin
                m_rdt = 32'd0;
                m_pop = 1'b0;
            end
            if (do_pop) void'(q.pop_front());
            if (f_push) begin
                if (q.size() < DEPTH) q.push_back(e.d);
                else f_ovr = 1'b1;
            end
            if (req && i_wb_we && i_wb_adr) begin
                m_irq_en = i_wb_dat[8];
                if (i_wb_dat[2]) m_ovr = 1'b0;
                if (i_wb_dat[3]) m_ferr = 1'b0;
                if (i_wb_dat[4]) m_perr = 1'b0;
            end
            m_ovr  = m_ovr  | f_ovr;
            m_ferr = m_ferr | f_ferr;
            m_perr = m_perr | f_perr;
            m_ack  = req;
        end
    end

    // Cycle-by-cycle comparison on the falling edge.
    always @(negedge i_clk) begin
        if (chk_en) begin
            chk("ack", {31'd0, o_wb_ack}, {31'd0, m_ack});
            chk("rdt", o_wb_rdt, m_rdt);
            chk("irq", {31'd0, o_irq}, {31'd0, m_irq_en && ((q.size() > 0) || m_ovr)});
        end
    end

    function automatic logic good_par(input logic [7:0] d);
        return ^d;
    endfunction

    task automatic bus(input logic adr, input logic we, input logic [31:0] dat, output logic [31:0] rd);
        i_wb_adr = adr; i_wb_we = we; i_wb_dat = dat; i_wb_cyc = 1'b1;
        @(posedge i_clk); #1;
        chk("bus_ack", {31'd0, o_wb_ack}, 32'd1);
        rd = o_wb_rdt;
        @(posedge i_clk); #1;
        i_wb_cyc = 1'b0; i_wb_we = 1'b0; i_wb_dat = 32'd0;
    endtask

    task automatic bit_time();
        repeat (CPB) @(posedge i_clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
        ev_t e;
        e.due = cyc_cnt + FRAME_DUE;
        e.d = d;
        e.stop_ok = stop;
`ifdef SERVANT_UART_RX_PARITY_EN
        e.par_ok = (par == good_par(d));
`else
        e.par_ok = 1'b1;
`endif
        evq.push_back(e);
        i_rx = 1'b0;
        bit_time();
        for (int i = 0; i < 8; i++) begin
            i_rx = d[i];
            bit_time();
        end
`ifdef SERVANT_UART_RX_PARITY_EN
        i_rx = par;
        bit_time();
`endif
        i_rx = stop;
        bit_time();
    endtask

    task automatic idle(input int n);
        i_rx = 1'b1;
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    logic [31:0] rd;

    initial begin
        repeat (2) @(posedge i_clk);
        chk_en = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_irq", {31'd0, o_irq}, 32'd0);
        chk("rst_ack", {31'd0, o_wb_ack}, 32'd0);
        chk("rst_rdt", o_wb_rdt, 32'd0);
        i_rst_n = 1'b1;
        idle(3);
        bus(1'b1, 1'b0, 32'd0, rd); chk("status_reset", rd, 32'h0);

        send_frame(8'hA5, 1'b1, good_par(8'hA5)); idle(4);
        bus(1'b1, 1'b0, 32'd0, rd); chk("status_a5", rd, 32'h1);
        bus(1'b0, 1'b0, 32'd0, rd); chk("data_a5", rd, 32'hA5);
        bus(1'b1, 1'b0, 32'd0, rd); chk("status_after_a5", rd, 32'h0);

        i_rx = 1'b0; repeat (4) @(posedge i_clk); #1; idle(30);
        bus(1'b1, 1'b0, 32'd0, rd); chk("status_glitch", rd, 32'h0);
        send_frame(8'h3C, 1'b1, good_par(8'h3C)); idle(4);
        bus(1'b0, 1'b0, 32'd0, rd); chk("data_3c", rd, 32'h3C);

        send_frame(8'h3C, 1'b0, good_par(8'h3C));
        repeat (40) @(posedge i_clk); #1;
        idle(20);
        bus(1'b1, 1'b0, 32'd0, rd); chk("status_ferr", rd, 32'h8);
        bus(1'b1, 1'b1, 32'h8, rd);
        bus(1'b1, 1'b0, 32'd0, rd); chk("status_ferr_clr", rd, 32'h0);

        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1, good_par(8'(i))); idle(2);
        end
        bus(1'b1, 1'b0, 32'd0, rd); chk("status_full_ovr", rd, 32'h7);
        for (int i = 1; i <= 4; i++) begin
            bus(1'b0, 1'b0, 32'd0, rd); chk("data_seq", rd, 32'(i));
        end
        bus(1'b0, 1'b0, 32'd0, rd); chk("data_empty", rd, 32'h0);
        bus(1'b1, 1'b0, 32'd0, rd); chk("status_ovr_only", rd, 32'h4);
        bus(1'b1, 1'b1, 32'h4, rd);

        bus(1'b1, 1'b1, 32'h100, rd);
        fork
            send_frame(8'h55, 1'b1, good_par(8'h55));
            begin
                repeat (FRAME_DUE - 1) @(posedge i_clk); #2;
                chk("irq_before_push", {31'd0, o_irq}, 32'd0);
                @(posedge i_clk); #2;
                chk("irq_at_push", {31'd0, o_irq}, 32'd1);
            end
        join
        idle(3);
        bus(1'b1, 1'b0, 32'd0, rd); chk("status_irq", rd, 32'h101);
        bus(1'b0, 1'b0, 32'd0, rd); chk("data_55", rd, 32'h55);
        chk("irq_after_pop", {31'd0, o_irq}, 32'd0);
        bus(1'b1, 1'b1, 32'h0, rd);

`ifdef SERVANT_UART_RX_PARITY_EN
        send_frame(8'h01, 1'b1, 1'b0); idle(4);
        bus(1'b1, 1'b0, 32'd0, rd); chk("status_perr", rd, 32'h10);
        bus(1'b1, 1'b1, 32'h10, rd);
`endif

        for (int n = 0; n < 36; n++) begin
            logic [7:0] d;
            logic       stop;
            d = 8'($urandom);
            stop = ($urandom_range(0, 7) != 0);
            send_frame(d, stop, ($urandom_range(0, 9) == 0) ? !good_par(d) : good_par(d));
            idle($urandom_range(1, 6));
            repeat ($urandom_range(0, 3)) begin
                if ($urandom_range(0, 3) == 0)
                    bus(1'b1, 1'b1, {23'd0, 1'($urandom), 3'd0, 3'($urandom), 2'd0}, rd);
                else
                    bus(1'($urandom), 1'b0, 32'd0, rd);
            end
        end
        repeat (DEPTH + 1) bus(1'b0, 1'b0, 32'd0, rd);
        bus(1'b1, 1'b0, 32'd0, rd);
        idle(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
